// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants, FSM encoding and snapshot classification for the keypad scanner
package keypad_pkg;
   localparam int SNAP_W = 16;
   localparam logic [3:0] COL_RST = 4'b1110;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HELD = 2'd1, ST_LOCK = 2'd2} state_t;
   typedef enum logic [1:0] {CLS_NONE = 2'd0, CLS_SINGLE = 2'd1, CLS_MULTI = 2'd2} cls_t;
   typedef struct packed {
      cls_t       cls;
      logic [3:0] idx;
   } class_t;

   // Snapshot bits are active low; idx is meaningful only for CLS_SINGLE
   function automatic class_t classify(input logic [SNAP_W-1:0] snap);
      int unsigned zeros;
      class_t c;
      zeros = 0;
      c.idx = 4'd0;
      for (int i = 0; i < SNAP_W; i++)
         if (!snap[i]) begin
            zeros++;
            c.idx = 4'(i);
         end
      c.cls = zeros == 0 ? CLS_NONE : zeros == 1 ? CLS_SINGLE : CLS_MULTI;
      return c;
   endfunction
endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: accepts a full-scan snapshot once it repeats DEBOUNCE_SCANS times in a row
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [SNAP_W-1:0] snap_i,
   input  logic              scan_done_i,
   output logic              stable_o,
   output logic [SNAP_W-1:0] snap_o
);
   localparam int CW = $clog2(DEBOUNCE_SCANS);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_SCANS - 1);

   logic [SNAP_W-1:0] prev_q, prev_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              stable_q, stable_d;

   // stable_q pulses for one cycle per scan while the count sits at LAST
   always_comb begin
      cnt_d    = cnt_q;
      prev_d   = prev_q;
      stable_d = 1'b0;
      if (scan_done_i) begin
         cnt_d    = snap_i != prev_q ? '0 : cnt_q == LAST ? LAST : cnt_q + 1'b1;
         prev_d   = snap_i;
         stable_d = cnt_d == LAST;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         prev_q   <= '1;
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         prev_q   <= prev_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign stable_o = stable_q;
   assign snap_o   = prev_q;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scan with debounce, hex key code, valid strobe and lockout
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 16,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int CNT_W          = 16
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   output logic [3:0] o_Col,
   input  logic [3:0] i_Row,
   output logic [3:0] o_Key,
   output logic       o_KeyValid,
   output logic       o_KeyHeld,
   output logic       o_Multi
);
   logic [3:0]        sync1_q, sync2_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [3:0]        col_q, col_d;
   logic [1:0]        col_idx_q, col_idx_d;
   logic [SNAP_W-1:0] snap_q, snap_d;
   logic              scan_done_q, scan_done_d;
   logic              tick;
   logic              db_stable;
   logic [SNAP_W-1:0] db_snap;
   class_t            c;
   state_t            state_q, state_d;
   logic [3:0]        key_q, key_d;
   logic              valid_q, valid_d, held_q, held_d, multi_q, multi_d;

   assign tick = cnt_q == CNT_W'(SCAN_DIV - 1);

   // Rows are sampled at the end of each column period, then the column advances
   always_comb begin
      cnt_d       = tick ? '0 : cnt_q + 1'b1;
      col_d       = tick ? {col_q[2:0], col_q[3]} : col_q;
      col_idx_d   = tick ? col_idx_q + 2'd1 : col_idx_q;
      scan_done_d = tick && col_idx_q == 2'd3;
      snap_d      = snap_q;
      if (tick)
         for (int r = 0; r < 4; r++)
            snap_d[{2'(r), col_idx_q}] = sync2_q[r];
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         sync1_q     <= 4'b1111;
         sync2_q     <= 4'b1111;
         cnt_q       <= '0;
         col_q       <= COL_RST;
         col_idx_q   <= 2'd0;
         snap_q      <= '1;
         scan_done_q <= 1'b0;
      end else begin
         sync1_q     <= i_Row;
         sync2_q     <= sync1_q;
         cnt_q       <= cnt_d;
         col_q       <= col_d;
         col_idx_q   <= col_idx_d;
         snap_q      <= snap_d;
         scan_done_q <= scan_done_d;
      end
   end

   keypad_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
      .clk_i       (i_clk),
      .rst_ni      (i_rst_n),
      .snap_i      (snap_q),
      .scan_done_i (scan_done_q),
      .stable_o    (db_stable),
      .snap_o      (db_snap)
   );

   assign c = classify(db_snap);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         key_q   <= 4'd0;
         valid_q <= 1'b0;
         held_q  <= 1'b0;
         multi_q <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         valid_q <= valid_d;
         held_q  <= held_d;
         multi_q <= multi_d;
      end
   end

   // A different single key while held locks out instead of rolling over
   always_comb begin
      state_d = state_q;
      if (db_stable)
         case (state_q)
            ST_IDLE: state_d = c.cls == CLS_SINGLE ? ST_HELD : c.cls == CLS_MULTI ? ST_LOCK : ST_IDLE;
            ST_HELD: state_d = c.cls == CLS_SINGLE && c.idx == key_q ? ST_HELD :
                               c.cls == CLS_NONE ? ST_IDLE : ST_LOCK;
            ST_LOCK: state_d = c.cls == CLS_NONE ? ST_IDLE : ST_LOCK;
            default: state_d = ST_IDLE;
         endcase
   end

   always_comb begin
      key_d   = key_q;
      valid_d = 1'b0;
      held_d  = held_q;
      multi_d = multi_q;
      if (db_stable) begin
         if (state_q == ST_IDLE && c.cls == CLS_SINGLE) begin
            key_d   = c.idx;
            valid_d = 1'b1;
         end
         held_d  = state_d == ST_HELD;
         multi_d = state_q == ST_LOCK ? state_d == ST_LOCK && multi_q : c.cls == CLS_MULTI;
      end
   end

   assign o_Col      = col_q;
   assign o_Key      = key_q;
   assign o_KeyValid = valid_q;
   assign o_KeyHeld  = held_q;
   assign o_Multi    = multi_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed and randomized key-press scenarios against a key-set level model
module tb_keypad_scanner;
   localparam int SD = 8, DS = 3, SCAN = 4 * SD, LAT = (DS + 1) * SCAN + 3, STEP = 6 * SCAN;

   logic        clk = 1'b0, rst_n = 1'b0, force_low = 1'b0;
   logic [3:0]  col, row, key;
   logic        valid, held, multi;
   logic [15:0] pressed = '0;
   int          checks = 0, failures = 0, strobes = 0;
   int          base, lat, mst;
   logic [3:0]  mkey;
   logic        mmulti;

   always #5 clk = ~clk;

   // Physical keypad: a pressed key pulls its row low while its column is driven
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
   end

   always @(negedge clk) if (valid) strobes <= strobes + 1;

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS), .CNT_W(16)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .o_Col      (col),
      .i_Row      (force_low ? 4'h0 : row),
      .o_Key      (key),
      .o_KeyValid (valid),
      .o_KeyHeld  (held),
      .o_Multi    (multi)
   );

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_strobe(input int b, input int limit, output int l);
      l = 0;
      while (strobes == b && l < limit) begin
         tick();
         l++;
      end
   endtask

   initial begin
      #2000000;
      $fatal(1, "FAIL timeout: simulation did not finish");
   end

   initial begin
      force_low = 1'b1;
      rst_n = 1'b0;
      tick(3);
      check("rst_col", 16'(col), 16'(4'b1110));
      check("rst_key", 16'(key), 16'h0);
      check("rst_valid", 16'(valid), 16'h0);
      check("rst_held", 16'(held), 16'h0);
      check("rst_multi", 16'(multi), 16'h0);
      rst_n = 1'b1;
      tick(7);
      check("col_hold", 16'(col), 16'(4'b1110));
      tick(1);
      check("col_rot1", 16'(col), 16'(4'b1101));
      tick(SD);
      check("col_rot2", 16'(col), 16'(4'b1011));
      tick(SD);
      check("col_rot3", 16'(col), 16'(4'b0111));
      tick(SD);
      check("col_wrap", 16'(col), 16'(4'b1110));
      tick(STEP);
      check("allrows_multi", 16'(multi), 16'h1);
      check("allrows_nostrobe", 16'(strobes), 16'h0);
      force_low = 1'b0;
      tick(STEP);
      check("allrows_release", 16'(multi), 16'h0);

      base = strobes;
      pressed = 16'h1 << 6;
      wait_strobe(base, LAT, lat);
      check("t2_in_time", 16'(lat < LAT), 16'h1);
      tick(SCAN);
      check("t2_key", 16'(key), 16'h6);
      check("t2_held", 16'(held), 16'h1);
      check("t2_one_strobe", 16'(strobes - base), 16'h1);
      pressed = '0;
      lat = 0;
      while (held && lat < LAT) begin
         tick();
         lat++;
      end
      check("t2_release", 16'(held), 16'h0);
      tick(STEP);
      check("t2_no_more", 16'(strobes - base), 16'h1);

      lat = 0;
      while (col !== 4'b0111 && lat < 64) begin
         tick();
         lat++;
      end
      while (col !== 4'b1110 && lat < 128) begin
         tick();
         lat++;
      end
      check("t3_sync", 16'(col), 16'(4'b1110));
      tick(7);
      base = strobes;
      for (int h = 0; h < 10; h++) begin
         pressed = h % 2 == 0 ? 16'h1 << 6 : 16'h0;
         tick(20);
      end
      check("t3_no_bounce_strobe", 16'(strobes - base), 16'h0);
      pressed = 16'h1 << 6;
      wait_strobe(base, 2 * LAT, lat);
      tick(SCAN);
      check("t3_key", 16'(key), 16'h6);
      check("t3_one_strobe", 16'(strobes - base), 16'h1);
      pressed = '0;
      tick(STEP);

      base = strobes;
      pressed = 16'h8001;
      tick(STEP);
      check("t4_multi", 16'(multi), 16'h1);
      check("t4_held", 16'(held), 16'h0);
      check("t4_no_strobe", 16'(strobes - base), 16'h0);
      pressed = '0;
      tick(STEP);
      check("t4_release", 16'(multi), 16'h0);
      pressed = 16'h1 << 3;
      wait_strobe(base, LAT, lat);
      tick(1);
      check("t4_key3", 16'(key), 16'h3);
      pressed = '0;
      tick(STEP);

      base = strobes;
      pressed = 16'h1 << 5;
      wait_strobe(base, LAT, lat);
      tick(SCAN);
      check("t5_key5", 16'(key), 16'h5);
      check("t5_held", 16'(held), 16'h1);
      base = strobes;
      pressed = pressed | 16'h1 << 9;
      tick(STEP);
      check("t5_multi", 16'(multi), 16'h1);
      check("t5_not_held", 16'(held), 16'h0);
      pressed = 16'h1 << 9;
      tick(STEP);
      check("t5_no_rollover", 16'(strobes - base), 16'h0);
      check("t5_still_locked", 16'(multi), 16'h1);
      pressed = '0;
      tick(STEP);
      check("t5_unlock", 16'(multi), 16'h0);
      check("t5_no_strobe", 16'(strobes - base), 16'h0);
      pressed = 16'h1 << 9;
      wait_strobe(base, LAT, lat);
      tick(1);
      check("t5_key9", 16'(key), 16'h9);
      pressed = '0;
      tick(STEP);

      base = strobes;
      pressed = 16'h1 << 10;
      wait_strobe(base, LAT, lat);
      tick(SCAN);
      check("t6_keyA", 16'(key), 16'hA);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      check("t6_rst_key", 16'(key), 16'h0);
      check("t6_rst_held", 16'(held), 16'h0);
      check("t6_rst_col", 16'(col), 16'(4'b1110));
      base = strobes;
      wait_strobe(base, LAT + SCAN, lat);
      tick(1);
      check("t6_rekey", 16'(key), 16'hA);
      check("t6_reheld", 16'(held), 16'h1);
      check("t6_one_strobe", 16'(strobes - base), 16'h1);

      mst = 1;
      mkey = 4'hA;
      mmulti = 1'b0;
      for (int s = 0; s < 24; s++) begin
         logic [15:0] ks;
         logic [3:0]  k;
         int          n, exp_str;
         case ($urandom_range(0, 3))
            0: ks = '0;
            1, 2: ks = 16'h1 << $urandom_range(0, 15);
            default: ks = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
         endcase
         n = $countones(ks);
         k = 4'd0;
         for (int i = 0; i < 16; i++) if (ks[i]) k = 4'(i);
         exp_str = 0;
         if (mst == 0) begin
            if (n == 1) begin
               mst = 1;
               mkey = k;
               exp_str = 1;
            end else if (n > 1) begin
               mst = 2;
               mmulti = 1'b1;
            end
         end else if (mst == 1) begin
            if (n == 0) mst = 0;
            else if (n > 1) begin
               mst = 2;
               mmulti = 1'b1;
            end else if (k != mkey) mst = 2;
         end else if (n == 0) begin
            mst = 0;
            mmulti = 1'b0;
         end
         base = strobes;
         pressed = ks;
         tick(STEP);
         check("rnd_strobes", 16'(strobes - base), 16'(exp_str));
         check("rnd_key", 16'(key), 16'(mkey));
         check("rnd_held", 16'(held), 16'(mst == 1));
         check("rnd_multi", 16'(multi), 16'(mmulti));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
